// File: rtl/arb_pkg.sv
// Shared arbiter definitions: requester count, select width, FSM encoding and the
// round-robin search helper.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Walk from the farthest offset back to ptr so the closest set bit is the one kept.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [SEL_W-1:0]   ptr);
        pick_t            p;
        logic [SEL_W-1:0] idx;
        p = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                p.valid = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/hold_counter.sv
// Saturating up-counter that times how long the current grant has been held.
// Synchronous active-high reset; clear has priority over enable.
module hold_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] max_val,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q < max_val)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux, with a grant hold counter.
// Define ARB_TIMEOUT_EN to preempt an owner that reaches HOLD_MAX while others wait.
//
// state | meaning
// IDLE  | no owner; arbitrate req from ptr on the next edge
// GRANT | owner = sel; held until its req drops (or timeout preemption)
module mux_rr_arbiter
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic [CNT_W-1:0]   hold_cnt
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               hold_en;
    logic               timeout;
    pick_t              pick;

    assign pick = rr_pick(req, ptr_q);

`ifdef ARB_TIMEOUT_EN
    assign timeout = (hold_cnt == CNT_W'(HOLD_MAX)) && ((req & ~gnt_q) != '0);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        hold_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick.valid) begin
                    state_d = GRANT;
                    gnt_d   = NUM_REQ'(1) << pick.idx;
                    sel_d   = pick.idx;
                end
            end
            GRANT: begin
                if (!req[sel_q] || timeout) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = sel_q + SEL_W'(1);
                end else begin
                    hold_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
        end
    end

    // Cleared whenever the grant is not continuing, so every new grant starts at 0.
    hold_counter #(
        .CNT_W (CNT_W)
    ) u_hold_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (!hold_en),
        .enable  (hold_en),
        .max_val (CNT_W'(HOLD_MAX)),
        .cnt     (hold_cnt)
    );

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = (state_q == GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: behavioural owner/ptr model checked every cycle, plus
// directed literal checks; follows ARB_TIMEOUT_EN the same way the design does.
module tb_mux_rr_arbiter;

    localparam int HM = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    req = 4'b1111;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          busy;
    logic [CW-1:0] hold_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mux_rr_arbiter #(.HOLD_MAX(HM), .CNT_W(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .gnt      (gnt),
        .sel      (sel),
        .busy     (busy),
        .hold_cnt (hold_cnt)
    );

    always #5 clk = ~clk;

    // Model: owner = -1 when nobody holds the mux.
    typedef struct {
        int owner;
        int ptr;
        int hold;
        int sel;
    } mst_t;

    mst_t m = '{-1, 0, 0, 0};

    function automatic mst_t model_step(mst_t s, logic rst, logic [3:0] r);
        mst_t n;
        int   i;
        bit   to;
        n  = s;
        to = 1'b0;
        if (rst) begin
            n.owner = -1; n.ptr = 0; n.hold = 0; n.sel = 0;
        end else if (s.owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                i = (s.ptr + k) % 4;
                if (r[i] && n.owner < 0) begin
                    n.owner = i; n.sel = i; n.hold = 0;
                end
            end
        end else begin
`ifdef ARB_TIMEOUT_EN
            to = (s.hold == HM) && ((r & ~(4'b0001 << s.owner)) != 4'b0000);
`endif
            if (!r[s.owner] || to) begin
                n.ptr   = (s.owner + 1) % 4;
                n.owner = -1;
                n.hold  = 0;
            end else begin
                n.hold = (s.hold < HM) ? s.hold + 1 : HM;
            end
        end
        return n;
    endfunction

    always @(posedge clk) m <= model_step(m, reset, req);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_gnt",  {28'd0, gnt},  (m.owner < 0) ? 32'd0 : (32'd1 << m.owner));
            check("model_sel",  {30'd0, sel},  32'(m.sel));
            check("model_busy", {31'd0, busy}, (m.owner < 0) ? 32'd0 : 32'd1);
            check("model_hold", {28'd0, hold_cnt}, 32'(m.hold));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) step();
        check("rst_gnt",  {28'd0, gnt}, 32'h0);
        check("rst_sel",  {30'd0, sel}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_hold", {28'd0, hold_cnt}, 32'h0);
        reset = 1'b0;
        step();
        check("first_gnt", {28'd0, gnt}, 32'b0001);

        for (int k = 0; k < 5; k++) begin
            check("rr_gnt", {28'd0, gnt}, 32'd1 << (k % 4));
            if (k < 4) begin
                step();
                step();
                req = 4'b1111 & ~(4'b0001 << (k % 4));
                step();
                check("rr_idle", {28'd0, gnt}, 32'h0);
                req = 4'b1111;
                step();
            end
        end

        req = 4'b0000; step();
        req = 4'b0100; step();
        check("set_gnt2", {28'd0, gnt}, 32'b0100);
        req = 4'b0000; step();
        req = 4'b0101; step();
        check("wrap_gnt", {28'd0, gnt}, 32'b0001);
        check("wrap_sel", {30'd0, sel}, 32'd0);
        req = 4'b0000; step();
        req = 4'b0101; step();
        check("wrap2_gnt", {28'd0, gnt}, 32'b0100);
        check("wrap2_sel", {30'd0, sel}, 32'd2);

        step();
        reset = 1'b1; step();
        check("midrst_gnt",  {28'd0, gnt}, 32'h0);
        check("midrst_busy", {31'd0, busy}, 32'h0);
        reset = 1'b0;
        req = 4'b1010; step();
        check("postrst_gnt", {28'd0, gnt}, 32'b0010);

        req = 4'b0000; step();
        req = 4'b0001; step();
        check("to_gnt0", {28'd0, gnt}, 32'b0001);
        req = 4'b0101;
        for (int j = 1; j <= 3; j++) begin
            step();
            check("to_hold_gnt", {28'd0, gnt}, 32'b0001);
            check("to_hold_cnt", {28'd0, hold_cnt}, 32'(j));
        end
`ifdef ARB_TIMEOUT_EN
        step();
        check("to_release", {28'd0, gnt}, 32'h0);
        step();
        check("to_next", {28'd0, gnt}, 32'b0100);
        req = 4'b0000; step();
        req = 4'b0001; step();
        repeat (3) step();
        repeat (20) begin
            step();
            check("alone_gnt",  {28'd0, gnt}, 32'b0001);
            check("alone_hold", {28'd0, hold_cnt}, 32'd3);
        end
`else
        repeat (20) begin
            step();
            check("nto_gnt",  {28'd0, gnt}, 32'b0001);
            check("nto_hold", {28'd0, hold_cnt}, 32'd3);
        end
`endif

        req = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            step();
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 149) == 0);
        end
        reset = 1'b0;
        step();
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
